debounce_multi: RTL and testbench

Parametrised N-channel switch debouncer. Each channel runs an independent four-state filter with its own hold-time counter and reports a debounced level plus single-cycle rising and falling edge ticks. It sits between raw board inputs (buttons, slide switches) and synchronous control logic. This is the multi-channel, bidirectional-tick successor of the single-switch debouncer control path.

---
 rtl/debounce_multi.sv | 139 +++++++++++++
 tb/tb_debounce_multi.sv | 129 ++++++++++++
 2 files changed

// File: rtl/debounce_multi.sv
// debounce_multi: N-channel switch debouncer.
// Each channel runs its own ZERO/WAIT1/ONE/WAIT0 filter with a per-channel
// hold counter. The outputs are registered: a debounced level, a one-cycle
// rise tick and a one-cycle fall tick per channel, plus any_tick, which is
// the OR of all ticks.
// Optional build macro: DEBOUNCE_SYNC_EN. When it is defined, each sw bit
// passes through a two-flop synchroniser before its filter, which adds
// 2 cycles of latency.
module debounce_multi #(
  parameter int unsigned N    = 4,
  parameter int unsigned HOLD = 1000000,
  parameter int unsigned CW   = (HOLD > 1) ? $clog2(HOLD) : 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] sw,
  output logic [N-1:0] db_level,
  output logic [N-1:0] rise_tick,
  output logic [N-1:0] fall_tick,
  output logic         any_tick
);

  typedef enum logic [1:0] {
    ZERO  = 2'b00,
    WAIT1 = 2'b01,
    ONE   = 2'b11,
    WAIT0 = 2'b10
  } state_t;

  // Value loaded when qualification of a new level starts.
  // When HOLD is 1, this value is 0.
  localparam logic [CW-1:0] LOAD = CW'(HOLD - 1);

  logic [N-1:0]  sw_s;
  state_t        state_q [N];
  state_t        state_d [N];
  logic [CW-1:0] cnt_q   [N];
  logic [CW-1:0] cnt_d   [N];
  logic [N-1:0]  rise_d;
  logic [N-1:0]  fall_d;
  logic [N-1:0]  level_d;

`ifdef DEBOUNCE_SYNC_EN
  logic [N-1:0] sync_q1;
  logic [N-1:0] sync_q2;

  // Two-flop synchroniser that brings the raw inputs into the clk domain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q1 <= '0;
      sync_q2 <= '0;
    end else begin
      sync_q1 <= sw;
      sync_q2 <= sync_q1;
    end
  end

  assign sw_s = sync_q2;
`else
  assign sw_s = sw;
`endif

  // Next-state, counter and tick terms for each channel.
  // The decrement happens only after cnt==0 has been checked, so the
  // counter never underflows.
  always_comb begin
    rise_d  = '0;
    fall_d  = '0;
    level_d = '0;
    for (int unsigned i = 0; i < N; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      case (state_q[i])
        ZERO: begin
          if (sw_s[i]) begin
            state_d[i] = WAIT1;
            cnt_d[i]   = LOAD;
          end
        end
        WAIT1: begin
          if (!sw_s[i]) begin
            state_d[i] = ZERO;
          end else if (cnt_q[i] == '0) begin
            state_d[i] = ONE;
            rise_d[i]  = 1'b1;
          end else begin
            cnt_d[i] = cnt_q[i] - CW'(1);
          end
        end
        ONE: begin
          if (!sw_s[i]) begin
            state_d[i] = WAIT0;
            cnt_d[i]   = LOAD;
          end
        end
        WAIT0: begin
          if (sw_s[i]) begin
            state_d[i] = ONE;
          end else if (cnt_q[i] == '0) begin
            state_d[i] = ZERO;
            fall_d[i]  = 1'b1;
          end else begin
            cnt_d[i] = cnt_q[i] - CW'(1);
          end
        end
        default: begin
          state_d[i] = ZERO;
        end
      endcase
      level_d[i] = (state_d[i] == ONE) || (state_d[i] == WAIT0);
    end
  end

  // Channel state, counters and registered outputs.
  // Each output is registered from the same next-state terms, so level,
  // ticks and any_tick all change on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < N; i++) begin
        state_q[i] <= ZERO;
        cnt_q[i]   <= '0;
      end
      db_level  <= '0;
      rise_tick <= '0;
      fall_tick <= '0;
      any_tick  <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < N; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      db_level  <= level_d;
      rise_tick <= rise_d;
      fall_tick <= fall_d;
      any_tick  <= |{rise_d, fall_d};
    end
  end

endmodule

// File: tb/tb_debounce_multi.sv
// Table-driven bench for debounce_multi with N=4 and HOLD=4 (default build).
// Each vector applies sw, waits for one rising edge, and then compares
// {db_level, rise_tick, fall_tick, any_tick} 1 time unit later.
module tb_debounce_multi;

  localparam int unsigned N    = 4;
  localparam int unsigned HOLD = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] sw  = '0;
  logic [N-1:0] db_level;
  logic [N-1:0] rise_tick;
  logic [N-1:0] fall_tick;
  logic         any_tick;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [3:0] sw;
    logic [3:0] lvl;
    logic [3:0] rise;
    logic [3:0] fall;
    logic       any;
  } vec_t;

  vec_t vecs [80];
  int   nv = 0;

  debounce_multi #(
    .N    (N),
    .HOLD (HOLD)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .sw        (sw),
    .db_level  (db_level),
    .rise_tick (rise_tick),
    .fall_tick (fall_tick),
    .any_tick  (any_tick)
  );

  always #5 clk = ~clk;

  task automatic push(input int reps, input logic [3:0] s, input logic [3:0] l,
                      input logic [3:0] r, input logic [3:0] f, input logic a);
    for (int k = 0; k < reps; k++) begin
      vecs[nv].sw   = s;
      vecs[nv].lvl  = l;
      vecs[nv].rise = r;
      vecs[nv].fall = f;
      vecs[nv].any  = a;
      nv++;
    end
  endtask

  task automatic check(input string name, input logic [3:0] l, input logic [3:0] r,
                       input logic [3:0] f, input logic a);
    total++;
    if ({db_level, rise_tick, fall_tick, any_tick} !== {l, r, f, a}) begin
      bad++;
      $display("FAIL %s: got lvl=%b rise=%b fall=%b any=%b, want lvl=%b rise=%b fall=%b any=%b",
               name, db_level, rise_tick, fall_tick, any_tick, l, r, f, a);
    end
  endtask

  initial begin
    // Channel 0 rises; the new level is accepted on the 5th edge.
    push(4, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 1'b0);
    push(1, 4'b0001, 4'b0001, 4'b0001, 4'b0000, 1'b1);
    push(5, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 1'b0);
    // Channel 1 glitches for 3 cycles: no change.
    push(3, 4'b0011, 4'b0001, 4'b0000, 4'b0000, 1'b0);
    push(2, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 1'b0);
    // Channel 1 glitches for exactly HOLD cycles: still no change.
    push(4, 4'b0011, 4'b0001, 4'b0000, 4'b0000, 1'b0);
    push(2, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 1'b0);
    // Channel 0 bounces (2 cycles low, 2 high), then falls for good.
    push(2, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 1'b0);
    push(2, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 1'b0);
    push(4, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 1'b0);
    push(1, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 1'b1);
    push(1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0);
    // Channels 2 and 3 rise together and tick together.
    push(4, 4'b1100, 4'b0000, 4'b0000, 4'b0000, 1'b0);
    push(1, 4'b1100, 4'b1100, 4'b1100, 4'b0000, 1'b1);
    push(2, 4'b1100, 4'b1100, 4'b0000, 4'b0000, 1'b0);

    // Check the reset state while reset is held.
    repeat (2) @(posedge clk);
    #1 check("reset_state", 4'b0000, 4'b0000, 4'b0000, 1'b0);
    rst = 1'b0;

    for (int v = 0; v < nv; v++) begin
      sw = vecs[v].sw;
      @(posedge clk);
      #1 check($sformatf("vec%0d", v), vecs[v].lvl, vecs[v].rise, vecs[v].fall, vecs[v].any);
    end

    // Reset while channel 0 is in WAIT1 with cnt=1.
    // At the same time, channels 2 and 3 are in WAIT0.
    sw = 4'b0001;
    for (int e = 0; e < 3; e++) begin
      @(posedge clk);
      #1 check($sformatf("pre_rst%0d", e), 4'b1100, 4'b0000, 4'b0000, 1'b0);
    end
    rst = 1'b1;
    #1 check("rst_async", 4'b0000, 4'b0000, 4'b0000, 1'b0);
    @(posedge clk);
    #1 check("rst_held", 4'b0000, 4'b0000, 4'b0000, 1'b0);
    rst = 1'b0;
    // After reset, a full requalification is required.
    for (int e = 0; e < 4; e++) begin
      @(posedge clk);
      #1 check($sformatf("post_rst%0d", e), 4'b0000, 4'b0000, 4'b0000, 1'b0);
    end
    @(posedge clk);
    #1 check("post_rst_rise", 4'b0001, 4'b0001, 4'b0000, 1'b1);
    for (int e = 0; e < 3; e++) begin
      @(posedge clk);
      #1 check($sformatf("post_rst_hold%0d", e), 4'b0001, 4'b0000, 4'b0000, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
